// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: decodes IR[15:12] and the accumulator flags into
// ALU mode, datapath selects, register enables and the memory handshake.
module mu0_control #(
    parameter int unsigned WAITMAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] F,
    input  logic       Zflag,
    input  logic       Nflag,
    input  logic       mem_ack,
    output logic [1:0] M,
    output logic       Asel,
    output logic       Xsel,
    output logic       Ysel,
    output logic       ACCce,
    output logic       PCce,
    output logic       IRce,
    output logic       ACCoe,
    output logic       MEMrq,
    output logic       RnW,
    output logic       Halted,
    output logic       BusErr
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAITMAX);

    localparam logic [1:0] M_ACC = 2'b00;
    localparam logic [1:0] M_ADD = 2'b01;
    localparam logic [1:0] M_PCI = 2'b10;
    localparam logic [1:0] M_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             buserr_q, buserr_d;
    logic             jump_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            buserr_q <= buserr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        buserr_d   = buserr_q;
        jump_taken = 1'b0;
        M          = M_ACC;
        Asel       = 1'b0;
        Xsel       = 1'b0;
        Ysel       = 1'b0;
        ACCce      = 1'b0;
        PCce       = 1'b0;
        IRce       = 1'b0;
        ACCoe      = 1'b0;
        MEMrq      = 1'b0;
        RnW        = 1'b0;
        Halted     = 1'b0;
        BusErr     = buserr_q;

        unique case (state_q)
            S_FETCH: begin
                MEMrq = 1'b1;
                RnW   = 1'b1;
                Xsel  = 1'b1;
                M     = M_PCI;
                if (mem_ack) begin
                    IRce    = 1'b1;
                    PCce    = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (F)
                    4'h0, 4'h2, 4'h3: begin
                        MEMrq = 1'b1;
                        RnW   = 1'b1;
                        Asel  = 1'b1;
                        M     = (F == 4'h2) ? M_ADD : ((F == 4'h3) ? M_SUB : M_ACC);
                        ACCce = mem_ack;
                        if (mem_ack) state_d = S_FETCH;
                    end
                    4'h1: begin
                        MEMrq = 1'b1;
                        Asel  = 1'b1;
                        ACCoe = 1'b1;
                        if (mem_ack) state_d = S_FETCH;
                    end
                    4'h4: begin
                        jump_taken = 1'b1;
                        state_d    = S_FETCH;
                    end
                    4'h5: begin
                        jump_taken = ~Nflag;
                        state_d    = S_FETCH;
                    end
                    4'h6: begin
                        jump_taken = ~Zflag;
                        state_d    = S_FETCH;
                    end
                    4'h7: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
                if (jump_taken) begin
                    Ysel = 1'b1;
                    PCce = 1'b1;
                end
            end
            S_HALT: Halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Wait counter runs only while a transfer is outstanding; ack wins on the limit cycle.
        if (MEMrq && !mem_ack) begin
            wait_d = CNT_W'(wait_q + 1'b1);
            if (wait_d == WAIT_LIMIT) begin
                state_d  = S_HALT;
                buserr_d = 1'b1;
                wait_d   = '0;
            end
        end

        if (reset) begin
            M      = '0;
            Asel   = 1'b0;
            Xsel   = 1'b0;
            Ysel   = 1'b0;
            ACCce  = 1'b0;
            PCce   = 1'b0;
            IRce   = 1'b0;
            ACCoe  = 1'b0;
            MEMrq  = 1'b0;
            RnW    = 1'b0;
            Halted = 1'b0;
            BusErr = 1'b0;
        end
    end

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Fetch/execute sequencer for the MU0 processor.
- Drives the 16-bit ALU mode select, the datapath multiplexer selects, the register clock enables and the memory request/handshake signals.
- Sits directly upstream of the ALU: its M output is the ALU's mode input.
- Decodes the 4-bit opcode held in IR[15:12] and the accumulator flags.

Parameters:
- WAITMAX, 15: maximum memory wait cycles before the bus-error halt; valid range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- F  input  4  opcode from IR[15:12]; stable while not fetching.
- Zflag  input  1  accumulator == 0.
- Nflag  input  1  accumulator bit 15.
- mem_ack  input  1  memory transfer complete; single-cycle pulse.
- M  output  2  ALU mode: 00 Acc (Z=Y), 01 Add, 10 PCi (Z=X+1), 11 Sub.
- Asel  output  1  address bus source: 0 = PC, 1 = IR[11:0].
- Xsel  output  1  ALU X source: 0 = ACC, 1 = PC.
- Ysel  output  1  ALU Y source: 0 = memory data, 1 = IR[11:0] zero-extended.
- ACCce  output  1  accumulator load enable.
- PCce  output  1  PC load enable (loads ALU Z).
- IRce  output  1  IR load enable (loads memory data).
- ACCoe  output  1  ACC drives the memory write data.
- MEMrq  output  1  memory request.
- RnW  output  1  1 = read, 0 = write.
- Halted  output  1  processor stopped.
- BusErr  output  1  halted due to memory timeout.

Behaviour:
- States: FETCH, EXEC, HALT. Encoding is 2 bits and is free.
- Reset (asynchronous):
  - Sets state to FETCH, the wait counter to 0, and Halted/BusErr to 0.
  - While reset is high, every output is 0, including MEMrq and the enables.
  - Reset mid-transfer abandons the transfer. The next cycle after release is a fresh FETCH.
- Output timing:
  - Outputs are combinational from state, F, flags and mem_ack.
  - Enables (ACCce, PCce, IRce) pulse only in the cycle where the transfer completes.
- FETCH:
  - MEMrq=1, RnW=1, Asel=0, Xsel=1, M=10.
  - When mem_ack=1: IRce=1 and PCce=1 in that cycle, then go to EXEC.
  - Otherwise stay in FETCH.
- EXEC, by opcode F:
  - 0 LDA: MEMrq=1, RnW=1, Asel=1, Ysel=0, M=00. On ack: ACCce=1, go to FETCH.
  - 1 STO: MEMrq=1, RnW=0, Asel=1, ACCoe=1. On ack: go to FETCH. No enable asserted.
  - 2 ADD: as LDA with Xsel=0, M=01.
  - 3 SUB: as LDA with Xsel=0, M=11.
  - 4 JMP: Ysel=1, M=00, PCce=1. One cycle, no memory access, then FETCH.
  - 5 JGE: if Nflag=0, behaves as JMP. Otherwise no enables. Either way one cycle, then FETCH.
  - 6 JNE: if Zflag=0, behaves as JMP. Otherwise as a not-taken JGE.
  - 7 STP: go to HALT. No enables.
  - 8..F: NOP. One cycle with no enables, then FETCH.
- HALT:
  - Halted=1 and all other control outputs are 0.
  - Exited only by reset.
- Memory handshake:
  - MEMrq and the address/RnW/select outputs stay constant until ack.
  - mem_ack is ignored whenever MEMrq=0.
  - Flags are sampled combinationally in the EXEC cycle only.
- Wait counter:
  - 8 bits; increments on each MEMrq=1 cycle without ack; cleared on ack or on a state change.
  - If the counter reaches WAITMAX without ack, the next state is HALT with BusErr=1.
  - An ack arriving in the same cycle the counter reaches WAITMAX wins: the transfer completes normally.
- Latency with an immediate ack:
  - Memory-reference instructions: 2 cycles (FETCH + EXEC).
  - Jumps and NOPs: 2 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset release, then ack held 0 for 3 cycles and pulsed on the 4th -> MEMrq=1, RnW=1, M=10, Asel=0 for 4 cycles; IRce=PCce=1 only in the 4th cycle; EXEC next.
- F=2 (ADD) with immediate acks -> EXEC cycle shows Asel=1, Xsel=0, M=01, ACCce=1; FETCH follows; total 2 cycles.
- F=1 (STO) with ack after 2 waits -> RnW=0, ACCoe=1 for 3 cycles; no ACCce/PCce/IRce pulses.
- F=5 with Nflag=1 -> no PCce; F=5 with Nflag=0 -> PCce=1, Ysel=1, M=00, MEMrq=0 in EXEC. Repeat with F=6 using Zflag.
- F=7 -> Halted=1 thereafter; ack pulses ignored and all enables 0 for 20 cycles; reset restores FETCH with Halted=0.
- WAITMAX=15 with no ack during FETCH -> HALT, Halted=1, BusErr=1 after the 15th wait cycle. Second run: ack on the 15th cycle -> normal EXEC, BusErr=0. Third run: reset asserted mid-wait -> all outputs 0 immediately.
